// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a word-organised data memory.
// Loads read one word and extract/extend the addressed byte, halfword or word.
// SW writes in the accept cycle. SB/SH read the word, merge the new lane and write it back.
// Optional feature: define MEM_BOUNDS_CHECK_EN to reject addresses above the memory.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr_word;
    logic [1:0]        r_lane;
    logic [2:0]        r_funct3;
    logic [15:0]       r_sdata;

    logic              w_idle_req;
    logic              w_load_f3_ok;
    logic              w_store_f3_ok;
    logic              w_misalign;
    logic              w_oob;
    logic              w_reject;
    logic              w_fault;
    logic              w_do_load;
    logic              w_do_sw;
    logic              w_do_rmw;
    logic [ADDR_W-1:0] w_req_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_ext;
    logic [31:0]       w_merged;

    // Request decode: only an IDLE cycle with a load or store is a real request.
    assign w_idle_req    = (r_state == IDLE) & req_valid & (is_load | is_store);
    assign w_load_f3_ok  = (funct3 != 3'b011) & (funct3[2:1] != 2'b11);
    assign w_store_f3_ok = ~funct3[2] & (funct3[1:0] != 2'b11);
    assign w_misalign    = ((funct3[1:0] == 2'b01) & addr[0]) |
                           ((funct3[1:0] == 2'b10) & (|addr[1:0]));

`ifdef MEM_BOUNDS_CHECK_EN
    assign w_oob = |addr[31:ADDR_W+2];
`else
    // Upper address bits are ignored: the access wraps within the memory.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^addr[31:ADDR_W+2];
    assign w_oob            = 1'b0;
`endif

    assign w_reject   = (is_load & is_store) | (is_load & ~w_load_f3_ok) |
                        (is_store & ~w_store_f3_ok) | w_misalign | w_oob;
    assign w_fault    = w_idle_req & w_reject;
    assign w_do_load  = w_idle_req & ~w_reject & is_load;
    // A legal store with funct3[1] set can only be SW; otherwise it is SB/SH.
    assign w_do_sw    = w_idle_req & ~w_reject & is_store & funct3[1];
    assign w_do_rmw   = w_idle_req & ~w_reject & is_store & ~funct3[1];
    assign w_req_word = addr[ADDR_W+1:2];

    // Load lane extraction and sign/zero extension from the word read last cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_load_ext = mem_rdata;
        w_byte     = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half     = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // RMW merge: replace the captured byte or halfword lane, keep the other bytes.
    always_comb begin
        w_merged = mem_rdata;
        if (r_funct3[0] == 1'b0) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_sdata[7:0];
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_sdata;
        end else begin
            w_merged[15:0] = r_sdata;
        end
    end

    // Memory-side outputs and stall; all forced low while reset is asserted.
    always_comb begin
        stall       = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 32'd0;
        mem_address = '0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    stall  = w_do_load | w_do_rmw;
                    mem_re = w_do_load | w_do_rmw;
                    mem_we = w_do_sw;
                    if (w_do_sw) begin
                        mem_wdata = store_data;
                    end
                    if (w_do_load | w_do_rmw | w_do_sw) begin
                        mem_address = w_req_word;
                    end
                end
                LOAD_WAIT: begin
                    mem_address = r_addr_word;
                end
                RMW_WAIT: begin
                    mem_we      = 1'b1;
                    mem_wdata   = w_merged;
                    mem_address = r_addr_word;
                end
                default: begin
                    mem_address = '0;
                end
            endcase
        end
    end

    // Control FSM with registered load result, load_valid and fault pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: capture registers are reset too, so a reset mid-access leaves no stale lane or data behind.
            r_state     <= IDLE;
            r_addr_word <= '0;
            r_lane      <= 2'd0;
            r_funct3    <= 3'd0;
            r_sdata     <= 16'd0;
            load_data   <= 32'd0;
            load_valid  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            fault      <= w_fault;
            case (r_state)
                IDLE: begin
                    if (w_do_load | w_do_rmw) begin
                        r_addr_word <= w_req_word;
                        r_lane      <= addr[1:0];
                        r_funct3    <= funct3;
                        r_sdata     <= store_data[15:0];
                        r_state     <= w_do_load ? LOAD_WAIT : RMW_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    load_data  <= w_load_ext;
                    load_valid <= 1'b1;
                    r_state    <= IDLE;
                end
                RMW_WAIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
